// File: rtl/valid_data_rx_pkg.sv
// Shared types, default parameters and the saturating counter helper for the valid/data sink.
package valid_data_rx_pkg;

    localparam int unsigned DEF_DATA_W    = 3;
    localparam int unsigned DEF_DEPTH     = 4;
    localparam int unsigned DEF_CNT_W     = 8;
    localparam int unsigned DEF_MATCH_VAL = 5;

    typedef enum logic [0:0] {
        RX_IDLE   = 1'b0,
        RX_ACTIVE = 1'b1
    } rx_state_e;

    // Increment that holds at max_v instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/valid_data_receiver_if.sv
// Stream, read-port and statistics bundle between the stimulus side and the receiver.
interface valid_data_receiver_if #(
    parameter int unsigned DATA_W = 3,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned LVL_W  = 3
);
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              ready;
    logic              rd_en;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic              match_seen;
    logic [CNT_W-1:0]  beat_cnt;
    logic [CNT_W-1:0]  burst_cnt;
    logic [CNT_W-1:0]  last_burst_len;

    modport master (
        output valid, data, rd_en,
        input  ready, rd_valid, rd_data, level, overflow, match_seen,
               beat_cnt, burst_cnt, last_burst_len
    );

    modport slave (
        input  valid, data, rd_en,
        output ready, rd_valid, rd_data, level, overflow, match_seen,
               beat_cnt, burst_cnt, last_burst_len
    );
endinterface

// File: rtl/valid_data_rx_fifo.sv
// First-word-fall-through FIFO with occupancy count; full/empty derive from the count.
module valid_data_rx_fifo #(
    parameter int unsigned DATA_W = 3,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [DATA_W-1:0]         wdata,
    output logic [DATA_W-1:0]         rdata,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      full,
    output logic                      empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [LVL_W-1:0]  level_q, level_d;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push) wptr_d = wptr_q + PTR_W'(1);
        if (pop)  rptr_d = rptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage is reset so the fall-through head reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) mem_q[wptr_q] <= wdata;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    assign rdata = mem_q[rptr_q];
    assign level = level_q;
    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);

endmodule

// File: rtl/valid_data_receiver.sv
// Sink for the valid/data stream: FIFO buffering, burst tracking and sticky match/overflow flags.
module valid_data_receiver
    import valid_data_rx_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned MATCH_VAL = DEF_MATCH_VAL
) (
    input  logic                          clk,
    input  logic                          rst,
    valid_data_receiver_if.slave          bus
);
    localparam logic [0:0]  IDLE    = RX_IDLE;
    localparam logic [0:0]  ACTIVE  = RX_ACTIVE;
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] run_len_q, run_len_d;
    logic [CNT_W-1:0] last_len_q, last_len_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             overflow_q, overflow_d;
    logic             match_q, match_d;

    logic full_c, empty_c, push_c, pop_c, ready_c;

    assign ready_c = !full_c;
    assign push_c  = bus.valid && ready_c;
    assign pop_c   = bus.rd_en && !empty_c;

    valid_data_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .pop   (pop_c),
        .wdata (bus.data),
        .rdata (bus.rd_data),
        .level (bus.level),
        .full  (full_c),
        .empty (empty_c)
    );

    always_comb begin
        state_d     = state_q;
        run_len_d   = run_len_q;
        last_len_d  = last_len_q;
        burst_cnt_d = burst_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        overflow_d  = overflow_q;
        match_d     = match_q;

        if (push_c) begin
            beat_cnt_d = CNT_W'(sat_inc(32'(beat_cnt_q), CNT_MAX));
            if (bus.data == DATA_W'(MATCH_VAL)) match_d = 1'b1;
        end
        if (bus.valid && !ready_c) overflow_d = 1'b1;

        // Burst length follows valid, including beats the FIFO drops.
        case (state_q)
            IDLE: begin
                if (bus.valid) begin
                    state_d   = ACTIVE;
                    run_len_d = CNT_W'(1);
                end
            end
            ACTIVE: begin
                if (bus.valid) begin
                    run_len_d = CNT_W'(sat_inc(32'(run_len_q), CNT_MAX));
                end else begin
                    state_d     = IDLE;
                    last_len_d  = run_len_q;
                    burst_cnt_d = CNT_W'(sat_inc(32'(burst_cnt_q), CNT_MAX));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            run_len_q   <= '0;
            last_len_q  <= '0;
            burst_cnt_q <= '0;
            beat_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            match_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_len_q   <= run_len_d;
            last_len_q  <= last_len_d;
            burst_cnt_q <= burst_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            overflow_q  <= overflow_d;
            match_q     <= match_d;
        end
    end

    assign bus.ready          = ready_c;
    assign bus.rd_valid       = !empty_c;
    assign bus.overflow       = overflow_q;
    assign bus.match_seen     = match_q;
    assign bus.beat_cnt       = beat_cnt_q;
    assign bus.burst_cnt      = burst_cnt_q;
    assign bus.last_burst_len = last_len_q;

endmodule

// File: tb/tb_valid_data_receiver.sv
// Directed bench: stimulus queues accepted beats, a negedge monitor checks every pop against them.
module tb_valid_data_receiver;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [2:0] sb_q [$];
    logic [2:0] mon_exp;

    valid_data_receiver_if #(.DATA_W(3), .CNT_W(8), .LVL_W(3)) bus ();

    valid_data_receiver #(
        .DATA_W    (3),
        .DEPTH     (4),
        .CNT_W     (8),
        .MATCH_VAL (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"},      32'(bus.ready),          32'd1);
        check({tag, "_rd_valid"},   32'(bus.rd_valid),       32'd0);
        check({tag, "_rd_data"},    32'(bus.rd_data),        32'd0);
        check({tag, "_level"},      32'(bus.level),          32'd0);
        check({tag, "_overflow"},   32'(bus.overflow),       32'd0);
        check({tag, "_match"},      32'(bus.match_seen),     32'd0);
        check({tag, "_beat_cnt"},   32'(bus.beat_cnt),       32'd0);
        check({tag, "_burst_cnt"},  32'(bus.burst_cnt),      32'd0);
        check({tag, "_last_len"},   32'(bus.last_burst_len), 32'd0);
    endtask

    // Apply one cycle of inputs; beats the bench expects to be accepted go to the scoreboard.
    task automatic drive(input logic v, input logic [2:0] d, input logic re, input logic acc);
        bus.valid = v;
        bus.data  = d;
        bus.rd_en = re;
        if (v && acc) sb_q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    // A pop happens at the next rising edge whenever rd_en and rd_valid are both high.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.rd_en && bus.rd_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got %0d expected no data", bus.rd_data);
                end else begin
                    mon_exp = sb_q.pop_front();
                    check("pop_data", 32'(bus.rd_data), 32'(mon_exp));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.valid = 1'b0;
        bus.data  = '0;
        bus.rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("in_rst");
        rst = 1'b0;
        repeat (5) drive(1'b0, 3'd0, 1'b0, 1'b0);
        check_reset("idle");

        // Single burst of three beats with data 3.
        repeat (3) drive(1'b1, 3'd3, 1'b0, 1'b1);
        check("sb_level",     32'(bus.level),     32'd3);
        check("sb_beat_cnt",  32'(bus.beat_cnt),  32'd3);
        check("sb_rd_data",   32'(bus.rd_data),   32'd3);
        check("sb_rd_valid",  32'(bus.rd_valid),  32'd1);
        check("sb_burst_mid", 32'(bus.burst_cnt), 32'd0);
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        check("sb_burst_cnt", 32'(bus.burst_cnt),      32'd1);
        check("sb_last_len",  32'(bus.last_burst_len), 32'd3);
        check("sb_match",     32'(bus.match_seen),     32'd0);
        repeat (3) drive(1'b0, 3'd0, 1'b1, 1'b0);
        check("drain1_level", 32'(bus.level),    32'd0);
        check("drain1_rdv",   32'(bus.rd_valid), 32'd0);

        // Overflow: six beats into a four-deep FIFO; 4 and 5 are dropped.
        drive(1'b1, 3'd0, 1'b0, 1'b1);
        drive(1'b1, 3'd1, 1'b0, 1'b1);
        drive(1'b1, 3'd2, 1'b0, 1'b1);
        check("ov_ready_3", 32'(bus.ready), 32'd1);
        drive(1'b1, 3'd3, 1'b0, 1'b1);
        check("ov_ready_4",    32'(bus.ready),    32'd0);
        check("ov_level_4",    32'(bus.level),    32'd4);
        check("ov_overflow_4", 32'(bus.overflow), 32'd0);
        drive(1'b1, 3'd4, 1'b0, 1'b0);
        check("ov_overflow_5", 32'(bus.overflow), 32'd1);
        drive(1'b1, 3'd5, 1'b0, 1'b0);
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        check("ov_level",     32'(bus.level),          32'd4);
        check("ov_beat_cnt",  32'(bus.beat_cnt),       32'd7);
        check("ov_overflow",  32'(bus.overflow),       32'd1);
        check("ov_match",     32'(bus.match_seen),     32'd0);
        check("ov_last_len",  32'(bus.last_burst_len), 32'd6);
        check("ov_burst_cnt", 32'(bus.burst_cnt),      32'd2);

        // Simultaneous push/pop from level 2 across the pointer wrap.
        repeat (2) drive(1'b0, 3'd0, 1'b1, 1'b0);
        check("pp_level_start", 32'(bus.level), 32'd2);
        drive(1'b1, 3'd6, 1'b1, 1'b1);
        check("pp_level_1", 32'(bus.level), 32'd2);
        drive(1'b1, 3'd7, 1'b1, 1'b1);
        check("pp_level_2", 32'(bus.level), 32'd2);
        drive(1'b1, 3'd0, 1'b1, 1'b1);
        check("pp_level_3", 32'(bus.level), 32'd2);
        drive(1'b1, 3'd1, 1'b1, 1'b1);
        check("pp_level_4",  32'(bus.level),    32'd2);
        check("pp_beat_cnt", 32'(bus.beat_cnt), 32'd11);
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        check("pp_burst_cnt", 32'(bus.burst_cnt),      32'd3);
        check("pp_last_len",  32'(bus.last_burst_len), 32'd4);
        check("pp_overflow",  32'(bus.overflow),       32'd1);
        repeat (2) drive(1'b0, 3'd0, 1'b1, 1'b0);
        check("drain2_level", 32'(bus.level), 32'd0);

        // Match value seen once stays sticky.
        drive(1'b1, 3'd5, 1'b0, 1'b1);
        check("m_match",    32'(bus.match_seen), 32'd1);
        check("m_beat_cnt", 32'(bus.beat_cnt),   32'd12);
        check("m_rd_data",  32'(bus.rd_data),    32'd5);
        repeat (10) drive(1'b0, 3'd0, 1'b0, 1'b0);
        check("m_match_hold", 32'(bus.match_seen),     32'd1);
        check("m_burst_cnt",  32'(bus.burst_cnt),      32'd4);
        check("m_last_len",   32'(bus.last_burst_len), 32'd1);
        drive(1'b0, 3'd0, 1'b1, 1'b0);
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        // Asynchronous reset in the middle of a burst with two entries queued.
        drive(1'b1, 3'd2, 1'b0, 1'b1);
        drive(1'b1, 3'd4, 1'b0, 1'b1);
        check("mr_level_pre", 32'(bus.level), 32'd2);
        #2;
        rst       = 1'b1;
        bus.valid = 1'b0;
        #1;
        check_reset("mr_async");
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) drive(1'b0, 3'd0, 1'b0, 1'b0);
        check("mr_burst_cnt", 32'(bus.burst_cnt),      32'd0);
        check("mr_last_len",  32'(bus.last_burst_len), 32'd0);
        check("mr_level",     32'(bus.level),          32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
